// File: rtl/rot_pkg.sv
// -----------------------------------------------------------------------------
// rot_pkg
// Shared definitions for the pipelined rotate/shift unit.
//   OP_ROR  rotate right
//   OP_ROL  rotate left
//   OP_SHR  logical shift right (vacated bits are 0)
//   OP_SHL  shift left (vacated bits are 0)
// -----------------------------------------------------------------------------
package rot_pkg;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_ROL = 2'b01;
  localparam logic [1:0] OP_SHR = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

endpackage : rot_pkg

// File: rtl/rot_stage.sv
// -----------------------------------------------------------------------------
// rot_stage
// One registered stage of the barrel rotator/shifter. When amt[log2(DIST)] is
// set, the stage moves the data by DIST positions in the direction and mode
// given by op. Control (valid, op, amt) and the optional carry travel through
// the stage alongside the data.
//
// Configuration macro: ROT_CARRY_EN adds the carry input and register.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   en          stage advance (deasserted while the pipe is stalled)
//   valid       incoming word valid
//   op          operation code (rot_pkg OP_*)
//   amt         full shift amount; this stage uses bit log2(DIST)
//   data        incoming data word
//   carry       incoming carry bit (ROT_CARRY_EN only)
//   valid_q .. carry_q   registered versions of the above, data moved
// -----------------------------------------------------------------------------
module rot_stage #(
  parameter int WIDTH = 8,
  parameter int DIST  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   amt,
  input  logic [WIDTH-1:0] data,
`ifdef ROT_CARRY_EN
  input  logic             carry,
  output logic             carry_q,
`endif
  output logic             valid_q,
  output logic [1:0]       op_q,
  output logic [SHW-1:0]   amt_q,
  output logic [WIDTH-1:0] data_q
);

  import rot_pkg::*;

  // Amount bit that selects this stage's move.
  localparam int BIT = $clog2(DIST);

  logic [WIDTH-1:0] moved;

  always_comb begin
    moved = data;
    if (amt[BIT]) begin
      case (op)
        OP_ROR:  moved = (data >> DIST) | (data << (WIDTH - DIST));
        OP_ROL:  moved = (data << DIST) | (data >> (WIDTH - DIST));
        OP_SHR:  moved = data >> DIST;
        default: moved = data << DIST;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset too, so dout reads 0 straight out of
      // reset instead of whatever the flops powered up with.
      valid_q <= 1'b0;
      op_q    <= '0;
      amt_q   <= '0;
      data_q  <= '0;
    end else if (en) begin
      // Empty stages still clock data; only the valid bit marks a real word.
      valid_q <= valid;
      op_q    <= op;
      amt_q   <= amt;
      data_q  <= moved;
    end
  end

`ifdef ROT_CARRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (en) begin
      carry_q <= carry;
    end
  end
`endif

endmodule : rot_stage

// File: rtl/rot_shift_pipe.sv
// -----------------------------------------------------------------------------
// rot_shift_pipe
// Pipelined WIDTH-bit rotate/shift unit with valid/ready flow control.
// log2(WIDTH) barrel stages; stage i moves by 2^i when in_amt[i] is set.
// Latency is $clog2(WIDTH) cycles; one word per cycle when not stalled.
// While the output is held (out_valid & ~out_ready) the whole pipe freezes
// and in_ready drops; in_ready depends only on out_valid/out_ready.
//
// Configuration macro: ROT_CARRY_EN adds dout_carry, the last bit moved out
// (0 for a zero amount), computed at the input and carried down the pipe.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    input word valid
//   in_ready    unit can accept a word this cycle
//   in_op       00 ROR, 01 ROL, 10 SHR, 11 SHL
//   in_amt      move amount 0..WIDTH-1
//   din         input data
//   out_valid   result valid
//   out_ready   consumer accepts result
//   dout        result data
//   dout_carry  last bit shifted/rotated out (ROT_CARRY_EN only)
// -----------------------------------------------------------------------------
module rot_shift_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [WIDTH-1:0]         din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         dout
`ifdef ROT_CARRY_EN
  ,
  output logic                     dout_carry
`endif
);

  import rot_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  // Index 0 is the pipe input; index i+1 is the output of stage i.
  logic             valid_c [SHW+1];
  logic [1:0]       op_c    [SHW+1];
  logic [SHW-1:0]   amt_c   [SHW+1];
  logic [WIDTH-1:0] data_c  [SHW+1];

  logic stall;
  logic advance;

  assign stall    = valid_c[SHW] & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

  // A word offered during a stall is not taken; the frozen pipe ignores it.
  assign valid_c[0] = in_valid;
  assign op_c[0]    = in_op;
  assign amt_c[0]   = in_amt;
  assign data_c[0]  = din;

`ifdef ROT_CARRY_EN
  logic           carry_c [SHW+1];
  logic [SHW-1:0] idx_r;
  logic [SHW-1:0] idx_l;

  // Right moves lose din[amt-1] last; left moves lose din[WIDTH-amt] last.
  // WIDTH-amt is taken modulo WIDTH, which is exact for any non-zero amount.
  always_comb begin
    idx_r      = in_amt - SHW'(1);
    idx_l      = SHW'(0) - in_amt;
    carry_c[0] = 1'b0;
    if (in_amt != '0) begin
      case (in_op)
        OP_ROR, OP_SHR: carry_c[0] = din[idx_r];
        default:        carry_c[0] = din[idx_l];
      endcase
    end
  end
`endif

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    rot_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << i),
      .SHW   (SHW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .valid   (valid_c[i]),
      .op      (op_c[i]),
      .amt     (amt_c[i]),
      .data    (data_c[i]),
`ifdef ROT_CARRY_EN
      .carry   (carry_c[i]),
      .carry_q (carry_c[i+1]),
`endif
      .valid_q (valid_c[i+1]),
      .op_q    (op_c[i+1]),
      .amt_q   (amt_c[i+1]),
      .data_q  (data_c[i+1])
    );
  end

  assign out_valid = valid_c[SHW];
  assign dout      = data_c[SHW];
`ifdef ROT_CARRY_EN
  assign dout_carry = carry_c[SHW];
`endif

  // The last stage's op/amt have no consumer beyond the pipe.
  logic unused_ctrl;
  assign unused_ctrl = ^{op_c[SHW], amt_c[SHW]};

endmodule : rot_shift_pipe

// File: tb/tb_rot_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_rot_shift_pipe
// Directed bench for rot_shift_pipe at WIDTH=8 (latency 3).
// Build with ROT_CARRY_EN defined to also check dout_carry.
// -----------------------------------------------------------------------------
module tb_rot_shift_pipe;

  import rot_pkg::*;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [SHW-1:0]   in_amt;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
`ifdef ROT_CARRY_EN
  logic             dout_carry;
`endif

  int checks = 0;
  int errors = 0;

  rot_shift_pipe #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_amt     (in_amt),
    .din        (din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (dout)
`ifdef ROT_CARRY_EN
    ,
    .dout_carry (dout_carry)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one word and returns out_valid sampled 1, 2 and 3 cycles later
  // (vhist[0..2]) plus the data/carry seen in the third cycle.
  task automatic run_one(input logic [1:0] op, input logic [SHW-1:0] amt,
                         input logic [WIDTH-1:0] d, output logic [2:0] vhist,
                         output logic [WIDTH-1:0] res, output logic resc);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_amt = amt; din = d;
    resc = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) in_valid = 1'b0;
      vhist[k-1] = out_valid;
    end
    res = dout;
`ifdef ROT_CARRY_EN
    resc = dout_carry;
`endif
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %b expected 00000000", dout); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
`ifdef ROT_CARRY_EN
    checks++;
    if (dout_carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b expected 0", dout_carry); end
`endif
  endtask

  // Directed single-word vectors with hand-computed results.
  task automatic test_vectors();
    logic [1:0]       v_op  [10];
    logic [SHW-1:0]   v_amt [10];
    logic [WIDTH-1:0] v_din [10];
    logic [WIDTH-1:0] v_exp [10];
    logic             v_c   [10];
    logic [2:0]       vh;
    logic [WIDTH-1:0] r;
    logic             rc;
    // rotate
    v_op[0] = OP_ROR; v_amt[0] = 3'd1; v_din[0] = 8'b10100001; v_exp[0] = 8'b11010000; v_c[0] = 1'b1;
    v_op[1] = OP_ROL; v_amt[1] = 3'd3; v_din[1] = 8'b10000001; v_exp[1] = 8'b00001100; v_c[1] = 1'b0;
    // shift
    v_op[2] = OP_SHR; v_amt[2] = 3'd4; v_din[2] = 8'b01111111; v_exp[2] = 8'b00000111; v_c[2] = 1'b1;
    v_op[3] = OP_SHL; v_amt[3] = 3'd1; v_din[3] = 8'b10000001; v_exp[3] = 8'b00000010; v_c[3] = 1'b1;
    // zero amount, every op
    v_op[4] = OP_ROR; v_amt[4] = 3'd0; v_din[4] = 8'b10100001; v_exp[4] = 8'b10100001; v_c[4] = 1'b0;
    v_op[5] = OP_ROL; v_amt[5] = 3'd0; v_din[5] = 8'b10100001; v_exp[5] = 8'b10100001; v_c[5] = 1'b0;
    v_op[6] = OP_SHR; v_amt[6] = 3'd0; v_din[6] = 8'b10100001; v_exp[6] = 8'b10100001; v_c[6] = 1'b0;
    v_op[7] = OP_SHL; v_amt[7] = 3'd0; v_din[7] = 8'b10100001; v_exp[7] = 8'b10100001; v_c[7] = 1'b0;
    // maximum amount
    v_op[8] = OP_ROR; v_amt[8] = 3'd7; v_din[8] = 8'b10100001; v_exp[8] = 8'b01000011; v_c[8] = 1'b0;
    v_op[9] = OP_SHL; v_amt[9] = 3'd7; v_din[9] = 8'b00000011; v_exp[9] = 8'b10000000; v_c[9] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_one(v_op[i], v_amt[i], v_din[i], vh, r, rc);
      checks++;
      if (vh !== 3'b100) begin errors++; $display("FAIL latency_%0d got valid history %b expected 100", i, vh); end
      checks++;
      if (r !== v_exp[i]) begin errors++; $display("FAIL dout_%0d got %b expected %b", i, r, v_exp[i]); end
`ifdef ROT_CARRY_EN
      checks++;
      if (rc !== v_c[i]) begin errors++; $display("FAIL carry_%0d got %b expected %b", i, rc, v_c[i]); end
`else
      if (rc !== 1'b0 && v_c[i] !== 1'bx) $display("unexpected carry value");
`endif
    end
  endtask

  // Six back-to-back words, out_ready low for cycles 2..5.
  task automatic test_back_to_back();
    logic [1:0]       b_op  [6];
    logic [SHW-1:0]   b_amt [6];
    logic [WIDTH-1:0] b_din [6];
    logic [WIDTH-1:0] b_exp [6];
    logic             b_c   [6];
    logic [2:0]       mv;
    logic             exp_stall;
    int               in_idx;
    int               out_idx;
    int               t;
    b_op[0] = OP_ROR; b_amt[0] = 3'd1; b_din[0] = 8'b10100001; b_exp[0] = 8'b11010000; b_c[0] = 1'b1;
    b_op[1] = OP_ROL; b_amt[1] = 3'd3; b_din[1] = 8'b10000001; b_exp[1] = 8'b00001100; b_c[1] = 1'b0;
    b_op[2] = OP_SHR; b_amt[2] = 3'd4; b_din[2] = 8'b01111111; b_exp[2] = 8'b00000111; b_c[2] = 1'b1;
    b_op[3] = OP_SHL; b_amt[3] = 3'd1; b_din[3] = 8'b10000001; b_exp[3] = 8'b00000010; b_c[3] = 1'b1;
    b_op[4] = OP_ROR; b_amt[4] = 3'd4; b_din[4] = 8'b11110000; b_exp[4] = 8'b00001111; b_c[4] = 1'b0;
    b_op[5] = OP_SHL; b_amt[5] = 3'd2; b_din[5] = 8'b00110011; b_exp[5] = 8'b11001100; b_c[5] = 1'b0;
    mv = 3'b000; in_idx = 0; out_idx = 0; t = 0;
    while ((in_idx < 6 || out_idx < 6) && t < 40) begin
      @(posedge clk); #1;
      out_ready = !(t >= 2 && t < 6);
      in_valid  = (in_idx < 6);
      if (in_idx < 6) begin
        in_op = b_op[in_idx]; in_amt = b_amt[in_idx]; din = b_din[in_idx];
      end
      @(negedge clk);
      exp_stall = mv[2] & ~out_ready;
      checks++;
      if (in_ready !== ~exp_stall) begin errors++; $display("FAIL b2b_in_ready_t%0d got %b expected %b", t, in_ready, ~exp_stall); end
      checks++;
      if (out_valid !== mv[2]) begin errors++; $display("FAIL b2b_out_valid_t%0d got %b expected %b", t, out_valid, mv[2]); end
      if (mv[2] && out_ready) begin
        checks++;
        if (dout !== b_exp[out_idx]) begin errors++; $display("FAIL b2b_dout_%0d got %b expected %b", out_idx, dout, b_exp[out_idx]); end
`ifdef ROT_CARRY_EN
        checks++;
        if (dout_carry !== b_c[out_idx]) begin errors++; $display("FAIL b2b_carry_%0d got %b expected %b", out_idx, dout_carry, b_c[out_idx]); end
`endif
        out_idx++;
      end
      if (!exp_stall) begin
        mv = {mv[1:0], in_valid};
        if (in_valid) in_idx++;
      end
      t++;
    end
    checks++;
    if (out_idx != 6) begin errors++; $display("FAIL b2b_count got %0d expected 6", out_idx); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup_%0d got %b expected 0", k, out_valid); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [2:0]       vh;
    logic [WIDTH-1:0] r;
    logic             rc;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = OP_ROL; in_amt = 3'(k + 1); din = 8'hC3;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_reset_valid got %b expected 1", out_valid); end
    rst = 1'b1;
    #1;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_%0d got %b expected 0", k, out_valid); end
    end
    run_one(OP_SHR, 3'd2, 8'b11001100, vh, r, rc);
    checks++;
    if (vh !== 3'b100) begin errors++; $display("FAIL mid_latency got valid history %b expected 100", vh); end
    checks++;
    if (r !== 8'b00110011) begin errors++; $display("FAIL mid_dout got %b expected 00110011", r); end
`ifdef ROT_CARRY_EN
    checks++;
    if (rc !== 1'b0) begin errors++; $display("FAIL mid_carry got %b expected 0", rc); end
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = OP_ROR; in_amt = '0; din = '0; out_ready = 1'b1;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_vectors();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rot_shift_pipe
